// File: rtl/div_iter_unit.sv
`timescale 1ns/1ps
// Multi-cycle restoring divider for MIPS DIV/DIVU. It works on magnitudes and uses an
// external leading-zero count of |dividend| so that only significant quotient bits are iterated.
module div_iter_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             SIGNED,
  input  logic [WIDTH-1:0] DIVIDEND,
  input  logic [WIDTH-1:0] DIVISOR,
  output logic [WIDTH-1:0] CLZ_DATA,
  input  logic [WIDTH-1:0] CLZ_COUNT,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] QUOTIENT,
  output logic [WIDTH-1:0] REMAINDER,
  output logic             DIV_ZERO
);

  typedef enum logic [2:0] {IDLE, LOAD, ALIGN, ITER, FIX} state_t;

  state_t      state_q;
  logic        signedOp_q;
  logic        dividendNeg_q;
  logic        divisorNeg_q;
  logic [31:0] clzData_q;
  logic [31:0] divisorMag_q;
  logic [31:0] shift_q;
  logic [31:0] rem_q;
  logic [31:0] quot_q;
  logic [5:0]  count_q;
  logic [31:0] quotient_q;
  logic [31:0] remainder_q;
  logic        busy_q;
  logic        done_q;
  logic        divZero_q;

  logic [31:0] dividendMag_d;
  logic [31:0] divisorMag_d;
  logic [5:0]  iterCount_d;
  logic [32:0] remShift_d;
  logic [32:0] remDiff_d;
  logic        remFits_d;
  logic [31:0] remNext_d;
  logic [31:0] quotSigned_d;
  logic [31:0] remSigned_d;
  logic [31:0] dividendRaw_d;
  logic        unusedCountBits;

  // The counter only ever reports 0..32, so the upper count bits carry no information.
  assign unusedCountBits = ^CLZ_COUNT[31:6];

  always_comb begin
    dividendMag_d = (SIGNED && DIVIDEND[31]) ? (~DIVIDEND + 32'd1) : DIVIDEND;
    divisorMag_d  = (SIGNED && DIVISOR[31])  ? (~DIVISOR + 32'd1)  : DIVISOR;
    iterCount_d   = 6'd32 - CLZ_COUNT[5:0];
    remShift_d    = {rem_q, shift_q[31]};
    // Partial remainder stays below the divisor, so bit 32 of the difference is a clean borrow.
    remDiff_d     = remShift_d - {1'b0, divisorMag_q};
    remFits_d     = ~remDiff_d[32];
    remNext_d     = remFits_d ? remDiff_d[31:0] : remShift_d[31:0];
    quotSigned_d  = (signedOp_q && (dividendNeg_q != divisorNeg_q)) ? (~quot_q + 32'd1) : quot_q;
    remSigned_d   = (signedOp_q && dividendNeg_q) ? (~rem_q + 32'd1) : rem_q;
    dividendRaw_d = (signedOp_q && dividendNeg_q) ? (~clzData_q + 32'd1) : clzData_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= IDLE;
      signedOp_q    <= 1'b0;
      dividendNeg_q <= 1'b0;
      divisorNeg_q  <= 1'b0;
      clzData_q     <= '0;
      divisorMag_q  <= '0;
      shift_q       <= '0;
      rem_q         <= '0;
      quot_q        <= '0;
      count_q       <= '0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      divZero_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (START) begin
            signedOp_q    <= SIGNED;
            dividendNeg_q <= SIGNED & DIVIDEND[31];
            divisorNeg_q  <= SIGNED & DIVISOR[31];
            clzData_q     <= dividendMag_d;
            divisorMag_q  <= divisorMag_d;
            busy_q        <= 1'b1;
            state_q       <= LOAD;
          end
        end
        LOAD: begin
          state_q <= ALIGN;
        end
        ALIGN: begin
          shift_q <= clzData_q << CLZ_COUNT[5:0];
          rem_q   <= '0;
          quot_q  <= '0;
          count_q <= iterCount_d;
          if ((iterCount_d != 6'd0) && (divisorMag_q != 32'd0)) begin
            state_q <= ITER;
          end else begin
            state_q <= FIX;
          end
        end
        ITER: begin
          rem_q   <= remNext_d;
          shift_q <= {shift_q[30:0], 1'b0};
          quot_q  <= {quot_q[30:0], remFits_d};
          count_q <= count_q - 6'd1;
          if (count_q == 6'd1) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          if (divisorMag_q == 32'd0) begin
            quotient_q  <= '1;
            remainder_q <= dividendRaw_d;
            divZero_q   <= 1'b1;
          end else begin
            quotient_q  <= quotSigned_d;
            remainder_q <= remSigned_d;
            divZero_q   <= 1'b0;
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign CLZ_DATA  = clzData_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign QUOTIENT  = quotient_q;
  assign REMAINDER = remainder_q;
  assign DIV_ZERO  = divZero_q;

endmodule

// File: tb/tb_div_iter_unit.sv
`timescale 1ns/1ps
// Directed bench for div_iter_unit: models the leading-zero counter and a cycle-level
// reference of the divider's visible behaviour, compared against the outputs every cycle.
module tb_div_iter_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signedOp;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] clzData;
  logic [31:0] clzCount;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        divZero;

  int checks = 0;
  int errors = 0;
  int cycleCount = 0;
  int startCycle = 0;
  bit checkEn = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  div_iter_unit #(.WIDTH(32)) dut (
    .CLK       (clk),
    .RST       (rst),
    .START     (start),
    .SIGNED    (signedOp),
    .DIVIDEND  (dividend),
    .DIVISOR   (divisor),
    .CLZ_DATA  (clzData),
    .CLZ_COUNT (clzCount),
    .BUSY      (busy),
    .DONE      (done),
    .QUOTIENT  (quotient),
    .REMAINDER (remainder),
    .DIV_ZERO  (divZero)
  );

  function automatic int clz32(input logic [31:0] v);
    int n;
    n = 32;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) n = 31 - i;
    end
    return n;
  endfunction

  // Upstream combinational leading-zero counter.
  always_comb clzCount = 32'(clz32(clzData));

  function automatic logic [31:0] refMag(input logic s, input logic [31:0] a);
    return (s && a[31]) ? (32'd0 - a) : a;
  endfunction

  function automatic logic [31:0] refQuot(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint la;
    longint lb;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    if (b == 32'd0) return 32'hFFFFFFFF;
    if (s) return 32'(la / lb);
    return a / b;
  endfunction

  function automatic logic [31:0] refRem(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint la;
    longint lb;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    if (b == 32'd0) return a;
    if (s) return 32'(la % lb);
    return a % b;
  endfunction

  function automatic int refLat(input logic s, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 3;
    return 35 - clz32(refMag(s, a));
  endfunction

  logic        mBusy = 1'b0;
  logic        mDone = 1'b0;
  logic        mDz = 1'b0;
  logic [31:0] mQ = '0;
  logic [31:0] mR = '0;
  logic [31:0] mClz = '0;
  logic [31:0] pQ = '0;
  logic [31:0] pR = '0;
  logic        pDz = 1'b0;
  int          mLeft = 0;

  // Reference: accepted operation completes refLat edges later; results hold until the next one.
  always @(posedge clk) begin
    mDone <= 1'b0;
    if (rst) begin
      mBusy <= 1'b0;
      mDz   <= 1'b0;
      mQ    <= '0;
      mR    <= '0;
      mClz  <= '0;
      mLeft <= 0;
    end else if (mBusy) begin
      mLeft <= mLeft - 1;
      if (mLeft == 1) begin
        mBusy <= 1'b0;
        mDone <= 1'b1;
        mQ    <= pQ;
        mR    <= pR;
        mDz   <= pDz;
      end
    end else if (start) begin
      pQ    <= refQuot(signedOp, dividend, divisor);
      pR    <= refRem(signedOp, dividend, divisor);
      pDz   <= (divisor == 32'd0);
      mLeft <= refLat(signedOp, dividend, divisor);
      mClz  <= refMag(signedOp, dividend);
      mBusy <= 1'b1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycleCount);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("busy", {31'd0, busy}, {31'd0, mBusy});
      checkOutput("done", {31'd0, done}, {31'd0, mDone});
      checkOutput("div_zero", {31'd0, divZero}, {31'd0, mDz});
      checkOutput("quotient", quotient, mQ);
      checkOutput("remainder", remainder, mR);
      checkOutput("clz_data", clzData, mClz);
    end
  end

  // Called at a negedge; returns just after the accepting edge with START dropped.
  task automatic applyStimulus(input logic s, input logic [31:0] a, input logic [31:0] b);
    signedOp = s;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
    startCycle = cycleCount;
  endtask

  task automatic waitDone(input string name, input logic [31:0] expQ, input logic [31:0] expR,
                          input logic expDz, input int expLat, input int expBusy);
    int  busyCycles;
    bit  seen;
    busyCycles = 0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else if (busy) busyCycles++;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout: no DONE within 60 cycles", name);
    end else begin
      checkOutput({name, " latency"}, 32'(cycleCount - startCycle), 32'(expLat));
      checkOutput({name, " q"}, quotient, expQ);
      checkOutput({name, " r"}, remainder, expR);
      checkOutput({name, " dz"}, {31'd0, divZero}, {31'd0, expDz});
      if (expBusy >= 0) checkOutput({name, " busy cycles"}, 32'(busyCycles), 32'(expBusy));
    end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    signedOp = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset q", quotient, 32'd0);
    checkOutput("reset clz", clzData, 32'd0);
    rst     = 1'b0;
    checkEn = 1'b1;

    applyStimulus(1'b0, 32'd100, 32'd7);
    waitDone("divu 100/7", 32'd14, 32'd2, 1'b0, 10, 10);

    applyStimulus(1'b1, 32'hFFFFFFF9, 32'd2);
    waitDone("div -7/2", 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 6, 6);

    applyStimulus(1'b1, 32'd7, 32'hFFFFFFFE);
    waitDone("div 7/-2", 32'hFFFFFFFD, 32'd1, 1'b0, 6, -1);

    applyStimulus(1'b0, 32'hFFFFFFFF, 32'd1);
    waitDone("divu max/1", 32'hFFFFFFFF, 32'd0, 1'b0, 35, 35);

    applyStimulus(1'b0, 32'd0, 32'd5);
    waitDone("divu 0/5", 32'd0, 32'd0, 1'b0, 3, 3);

    applyStimulus(1'b1, 32'h12345678, 32'd0);
    waitDone("div by zero", 32'hFFFFFFFF, 32'h12345678, 1'b1, 3, -1);

    applyStimulus(1'b1, 32'hFFFFFFF8, 32'd0);
    waitDone("div neg by zero", 32'hFFFFFFFF, 32'hFFFFFFF8, 1'b1, 3, -1);

    applyStimulus(1'b1, 32'h80000000, 32'hFFFFFFFF);
    waitDone("div overflow", 32'h80000000, 32'd0, 1'b0, 35, -1);

    // A START pulse mid-iteration must be ignored entirely.
    applyStimulus(1'b0, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    signedOp = 1'b1;
    dividend = 32'd50;
    divisor  = 32'd5;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone("ignored start", 32'd14, 32'd2, 1'b0, 10, -1);

    applyStimulus(1'b0, 32'd1000, 32'd10);
    waitDone("b2b first", 32'd100, 32'd0, 1'b0, 13, -1);
    applyStimulus(1'b0, 32'd9, 32'd4);
    waitDone("b2b second", 32'd2, 32'd1, 1'b0, 7, 7);

    applyStimulus(1'b0, 32'hFFFFFFFF, 32'd1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort busy", {31'd0, busy}, 32'd0);
    checkOutput("abort done", {31'd0, done}, 32'd0);
    checkOutput("abort q", quotient, 32'd0);
    checkOutput("abort r", remainder, 32'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    applyStimulus(1'b0, 32'd9, 32'd3);
    waitDone("divu 9/3", 32'd3, 32'd0, 1'b0, 7, 7);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
